// File: rtl/ads868x_scan_sched.sv
// ADS868x scan scheduler: steps the 32-channel analog mux and runs a conversion and a read SPI frame per enabled channel.
// Optional macro ADS868X_SCAN_PPS_SYNC_EN aligns scan_en-started scans to a registered pps rising edge.
module ads868x_scan_sched #(
    parameter int SETTLE_CYCLES = 200,
    parameter int CONV_CYCLES   = 100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        scan_en,
    input  logic        scan_trig,
    input  logic [31:0] chan_mask,
    input  logic        pps,
    output logic [2:0]  mux_sel,
    output logic [3:0]  mux_en,
    output logic [7:0]  spi_tx_tdata,
    output logic        spi_tx_tvalid,
    input  logic        spi_tx_tready,
    input  logic [7:0]  spi_rx_tdata,
    input  logic        spi_rx_tvalid,
    output logic        spi_rx_tready,
    output logic [31:0] m_axis_tdata,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        busy,
    output logic        scan_done
);
    typedef enum logic [3:0] {
        S_IDLE, S_BBM, S_SETTLE, S_CONV_TX, S_CONV_RX, S_CONV_WAIT, S_READ_TX, S_READ_RX, S_OUTPUT
    } state_t;

    localparam logic [31:0] LP_SETTLE_LAST = 32'(SETTLE_CYCLES - 1);
    localparam logic [31:0] LP_CONV_LAST   = 32'(CONV_CYCLES - 1);

    state_t      r_state;
    logic [31:0] r_mask, r_cnt, r_m_data;
    logic [4:0]  r_chan;
    logic [7:0]  r_seq, r_code_hi, r_code_lo;
    logic [1:0]  r_tx_cnt;
    logic [2:0]  r_rx_cnt, r_mux_sel;
    logic [3:0]  r_mux_en;
    logic        r_tx_vld, r_rx_rdy, r_m_vld, r_busy, r_done;
    logic        w_start, w_rx_hs, w_rx_last, w_in_frame, w_in_read;
    logic [5:0]  w_first, w_next;

    // Returns {found, index} of the lowest set bit.
    function automatic logic [5:0] f_lowest(input logic [31:0] mask);
        logic [5:0] res;
        res = 6'd0;
        for (int i = 31; i >= 0; i--)
            if (mask[i]) res = {1'b1, 5'(i)};
        return res;
    endfunction

`ifdef ADS868X_SCAN_PPS_SYNC_EN
    localparam bit LP_PPS_SYNC = 1'b1;
    logic r_pps_d, r_pps_rise;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pps_d    <= 1'b0;
            r_pps_rise <= 1'b0;
        end else begin
            r_pps_d    <= pps;
            r_pps_rise <= pps & ~r_pps_d;
        end
    end
    assign w_start = scan_trig | (scan_en & r_pps_rise);
`else
    localparam bit LP_PPS_SYNC = 1'b0;
    logic w_unused_pps;
    assign w_unused_pps = pps;
    assign w_start = scan_trig | scan_en;
`endif

    assign w_first    = f_lowest(chan_mask);
    assign w_next     = f_lowest(r_mask & ~((32'd2 << r_chan) - 32'd1));
    assign w_rx_hs    = spi_rx_tvalid & r_rx_rdy;
    assign w_in_read  = (r_state == S_READ_TX) || (r_state == S_READ_RX);
    assign w_in_frame = w_in_read || (r_state == S_CONV_TX) || (r_state == S_CONV_RX);
    // Rx bytes may already arrive while the tx half of the frame is still running.
    assign w_rx_last  = (r_rx_cnt == 3'd4) || (w_rx_hs && r_rx_cnt == 3'd3);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_seq     <= 8'd0;
            r_mux_sel <= 3'd0;
            r_mux_en  <= 4'd0;
            r_tx_vld  <= 1'b0;
            r_rx_rdy  <= 1'b0;
            r_m_vld   <= 1'b0;
            r_m_data  <= 32'd0;
            r_tx_cnt  <= 2'd0;
            r_rx_cnt  <= 3'd0;
            r_cnt     <= 32'd0;
        end else begin
            r_done   <= 1'b0;
            r_rx_rdy <= 1'b1;
            if (w_in_frame && w_rx_hs && r_rx_cnt != 3'd4) begin
                r_rx_cnt <= r_rx_cnt + 3'd1;
                if (w_in_read && r_rx_cnt == 3'd0) r_code_hi <= spi_rx_tdata;
                if (w_in_read && r_rx_cnt == 3'd1) r_code_lo <= spi_rx_tdata;
            end
            case (r_state)
                S_IDLE: if (w_start) begin
                    r_mask <= chan_mask;
                    if (!w_first[5]) begin
                        r_done <= 1'b1;
                        r_seq  <= r_seq + 8'd1;
                    end else begin
                        r_chan    <= w_first[4:0];
                        r_mux_sel <= w_first[2:0];
                        r_mux_en  <= 4'd0;
                        r_busy    <= 1'b1;
                        r_state   <= S_BBM;
                    end
                end
                S_BBM: begin
                    r_mux_en <= 4'd1 << r_chan[4:3];
                    r_cnt    <= 32'd0;
                    r_state  <= S_SETTLE;
                end
                S_SETTLE: if (r_cnt == LP_SETTLE_LAST) begin
                    r_tx_vld <= 1'b1;
                    r_tx_cnt <= 2'd0;
                    r_rx_cnt <= 3'd0;
                    r_state  <= S_CONV_TX;
                end else begin
                    r_cnt <= r_cnt + 32'd1;
                end
                S_CONV_TX, S_READ_TX: if (r_tx_vld && spi_tx_tready) begin
                    r_tx_cnt <= r_tx_cnt + 2'd1;
                    if (r_tx_cnt == 2'd3) begin
                        r_tx_vld <= 1'b0;
                        r_state  <= (r_state == S_CONV_TX) ? S_CONV_RX : S_READ_RX;
                    end
                end
                S_CONV_RX: if (w_rx_last) begin
                    r_cnt   <= 32'd0;
                    r_state <= S_CONV_WAIT;
                end
                S_CONV_WAIT: if (r_cnt == LP_CONV_LAST) begin
                    r_tx_vld <= 1'b1;
                    r_tx_cnt <= 2'd0;
                    r_rx_cnt <= 3'd0;
                    r_state  <= S_READ_TX;
                end else begin
                    r_cnt <= r_cnt + 32'd1;
                end
                S_READ_RX: if (w_rx_last) begin
                    r_m_vld  <= 1'b1;
                    r_m_data <= {3'b000, r_chan, r_seq, r_code_hi, r_code_lo};
                    r_state  <= S_OUTPUT;
                end
                S_OUTPUT: if (m_axis_tready) begin
                    r_m_vld <= 1'b0;
                    if (w_next[5]) begin
                        r_chan    <= w_next[4:0];
                        r_mux_sel <= w_next[2:0];
                        r_mux_en  <= 4'd0;
                        r_state   <= S_BBM;
                    end else begin
                        r_done <= 1'b1;
                        r_seq  <= r_seq + 8'd1;
                        // A continuous restart is a new scan start, so the mask is re-latched here.
                        if (scan_en && !LP_PPS_SYNC && w_first[5]) begin
                            r_mask    <= chan_mask;
                            r_chan    <= w_first[4:0];
                            r_mux_sel <= w_first[2:0];
                            r_mux_en  <= 4'd0;
                            r_state   <= S_BBM;
                        end else begin
                            r_busy  <= 1'b0;
                            r_state <= S_IDLE;
                        end
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign mux_sel       = r_mux_sel;
    assign mux_en        = r_mux_en;
    assign spi_tx_tdata  = 8'h00;
    assign spi_tx_tvalid = r_tx_vld;
    assign spi_rx_tready = r_rx_rdy;
    assign m_axis_tdata  = r_m_data;
    assign m_axis_tvalid = r_m_vld;
    assign busy          = r_busy;
    assign scan_done     = r_done;
endmodule

// File: tb/tb_ads868x_scan_sched.sv
// Bench for ads868x_scan_sched: randomized SPI slave model plus a scan-level expectation queue.
// Build with ADS868X_SCAN_PPS_SYNC_EN defined to also exercise pps-aligned scanning.
module tb_ads868x_scan_sched;
    localparam int SETTLE = 5;
    localparam int CONV   = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1, scan_en = 1'b0, scan_trig = 1'b0, pps = 1'b0;
    logic [31:0] chan_mask = 32'd0;
    logic        spi_tx_tready = 1'b0, spi_rx_tvalid = 1'b0, m_axis_tready = 1'b1;
    logic [7:0]  spi_rx_tdata = 8'h00;
    logic [2:0]  mux_sel;
    logic [3:0]  mux_en;
    logic [7:0]  spi_tx_tdata;
    logic        spi_tx_tvalid, spi_rx_tready, m_axis_tvalid, busy, scan_done;
    logic [31:0] m_axis_tdata;

    always #5 clk = ~clk;

    ads868x_scan_sched #(.SETTLE_CYCLES(SETTLE), .CONV_CYCLES(CONV)) dut (
        .clk(clk), .rst(rst), .scan_en(scan_en), .scan_trig(scan_trig), .chan_mask(chan_mask),
        .pps(pps), .mux_sel(mux_sel), .mux_en(mux_en), .spi_tx_tdata(spi_tx_tdata),
        .spi_tx_tvalid(spi_tx_tvalid), .spi_tx_tready(spi_tx_tready), .spi_rx_tdata(spi_rx_tdata),
        .spi_rx_tvalid(spi_rx_tvalid), .spi_rx_tready(spi_rx_tready), .m_axis_tdata(m_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready), .busy(busy), .scan_done(scan_done)
    );

    typedef struct packed { logic [4:0] ch; logic [7:0] seq; } exp_t;
    exp_t        exp_q[$];
    logic [15:0] codes_q[$];
    logic [7:0]  rx_q[$];
    int          vectors = 0, miscompares = 0;
    int          tx_bytes = 0, done_cnt = 0, samples = 0, bbm_cycles = 0, frame_bytes = 0;
    bit          rd_frame = 1'b0, force_en = 1'b0;
    logic [15:0] force_code = 16'h0, cur_code = 16'h0;
    logic [7:0]  m_seq = 8'd0;
    logic [31:0] last_word = 32'd0;
    logic        f_rst = 1'b1, f_tx_hs = 1'b0, f_rx_hs = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One scan of a mask yields one sample per set bit, lowest channel first, all tagged with the same sequence.
    task automatic expect_scan(input logic [31:0] mask);
        for (int c = 0; c < 32; c++)
            if (mask[c]) exp_q.push_back({5'(c), m_seq});
        m_seq++;
    endtask

    always @(negedge clk) begin : mon
        exp_t        e;
        logic [15:0] code;
        f_rst   = rst;
        f_tx_hs = spi_tx_tvalid && spi_tx_tready;
        f_rx_hs = spi_rx_tvalid && spi_rx_tready;
        if (!rst) begin
            if (f_tx_hs) begin
                tx_bytes++;
                chk("tx_byte_zero", 32'(spi_tx_tdata), 32'd0);
            end
            if (scan_done) done_cnt++;
            if (busy && mux_en == 4'd0) bbm_cycles++;
            if (m_axis_tvalid && m_axis_tready) begin
                samples++;
                last_word = m_axis_tdata;
                chk("sample_expected", 32'(exp_q.size() > 0 && codes_q.size() > 0), 32'd1);
                if (exp_q.size() > 0 && codes_q.size() > 0) begin
                    e    = exp_q.pop_front();
                    code = codes_q.pop_front();
                    chk("sample_word", m_axis_tdata, {3'b000, e.ch, e.seq, code});
                    chk("sample_mux_sel", 32'(mux_sel), 32'(e.ch[2:0]));
                    chk("sample_mux_en", 32'(mux_en), 32'(4'd1 << e.ch[4:3]));
                end
            end
        end
    end

    // SPI slave: every accepted tx byte queues one rx byte; the 2nd frame of each pair carries the code.
    always begin
        @(posedge clk); #1;
        if (f_rst) begin
            rx_q.delete(); codes_q.delete();
            frame_bytes = 0; rd_frame = 1'b0;
            spi_rx_tvalid = 1'b0; spi_tx_tready = 1'b0;
        end else begin
            if (f_rx_hs) void'(rx_q.pop_front());
            if (f_tx_hs) begin
                if (rd_frame && frame_bytes == 0) begin
                    cur_code = force_en ? force_code : 16'($urandom);
                    codes_q.push_back(cur_code);
                end
                if (rd_frame && frame_bytes == 0)      rx_q.push_back(cur_code[15:8]);
                else if (rd_frame && frame_bytes == 1) rx_q.push_back(cur_code[7:0]);
                else                                   rx_q.push_back(8'($urandom));
                frame_bytes++;
                if (frame_bytes == 4) begin
                    frame_bytes = 0;
                    rd_frame = !rd_frame;
                end
            end
            spi_tx_tready = ($urandom_range(0, 3) != 0);
            spi_rx_tvalid = (rx_q.size() != 0) && ($urandom_range(0, 3) != 0);
            spi_rx_tdata  = (rx_q.size() != 0) ? rx_q[0] : 8'h00;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic trig();
        scan_trig = 1'b1;
        @(posedge clk); #1;
        scan_trig = 1'b0;
    endtask

    task automatic wait_done(input int target, input int budget, input string tag);
        int k;
        k = 0;
        while (done_cnt < target && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk(tag, 32'(done_cnt >= target), 32'd1);
        @(posedge clk); #1;
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int k, base_tx, base_done, base_s;
        logic [31:0] w0;
        cyc(3);
        @(negedge clk);
        chk("rst_mux_sel", 32'(mux_sel), 32'd0);
        chk("rst_mux_en", 32'(mux_en), 32'd0);
        chk("rst_tx_tvalid", 32'(spi_tx_tvalid), 32'd0);
        chk("rst_tx_tdata", 32'(spi_tx_tdata), 32'd0);
        chk("rst_rx_tready", 32'(spi_rx_tready), 32'd0);
        chk("rst_m_tvalid", 32'(m_axis_tvalid), 32'd0);
        chk("rst_m_tdata", m_axis_tdata, 32'd0);
        chk("rst_busy_done", 32'({busy, scan_done}), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        cyc(3);

        // Single channel with a fixed read-frame code, plus an ignored trigger while busy.
        chan_mask = 32'h0000_0001; force_en = 1'b1; force_code = 16'hA53C;
        base_tx = tx_bytes; base_done = done_cnt;
        expect_scan(chan_mask);
        trig();
        @(negedge clk);
        chk("start_busy", 32'(busy), 32'd1);
        chk("bbm_mux_en", 32'(mux_en), 32'd0);
        chk("bbm_mux_sel", 32'(mux_sel), 32'd0);
        @(negedge clk);
        chk("settle_mux_en", 32'(mux_en), 32'd1);
        repeat (SETTLE - 1) @(negedge clk);
        chk("settle_no_tx_yet", 32'(spi_tx_tvalid), 32'd0);
        @(negedge clk);
        chk("conv_tx_starts", 32'(spi_tx_tvalid), 32'd1);
        @(posedge clk); #1;
        trig();
        wait_done(base_done + 1, 600, "single_done");
        cyc(5);
        chk("single_tx_bytes", 32'(tx_bytes - base_tx), 32'd8);
        chk("single_word", last_word, 32'h0000_A53C);
        chk("single_done_once", 32'(done_cnt - base_done), 32'd1);
        chk("single_idle", 32'(busy), 32'd0);
        force_en = 1'b0;

        // Multi-bank scan; a mid-scan mask change must not affect it.
        chan_mask = 32'h8000_0101; base_done = done_cnt; bbm_cycles = 0;
        expect_scan(chan_mask);
        trig();
        chan_mask = 32'h0000_0002;
        wait_done(base_done + 1, 1500, "multi_done");
        chk("multi_bbm_cycles", 32'(bbm_cycles), 32'd3);
        chk("multi_exp_left", 32'(exp_q.size()), 32'd0);
        chk("multi_mux_en_kept", 32'(mux_en), 32'b1000);

        // Backpressure: word held stable and SPI quiet until the handshake.
        chan_mask = 32'h0000_0010; base_done = done_cnt; m_axis_tready = 1'b0;
        expect_scan(chan_mask);
        trig();
        k = 0;
        while (!m_axis_tvalid && k < 600) begin @(negedge clk); k++; end
        chk("bp_valid_seen", 32'(m_axis_tvalid), 32'd1);
        w0 = m_axis_tdata; base_tx = tx_bytes;
        repeat (500) @(negedge clk);
        chk("bp_word_stable", m_axis_tdata, w0);
        chk("bp_valid_held", 32'(m_axis_tvalid), 32'd1);
        chk("bp_no_spi", 32'(tx_bytes - base_tx), 32'd0);
        @(posedge clk); #1;
        m_axis_tready = 1'b1;
        wait_done(base_done + 1, 100, "bp_done");
        chk("bp_exp_left", 32'(exp_q.size()), 32'd0);

        // Continuous scanning; scan_en drops mid-scan and that scan still completes.
        chan_mask = 32'h0000_0003; base_done = done_cnt; base_s = samples;
        repeat (4) expect_scan(chan_mask);
        scan_en = 1'b1;
        k = 0;
        while (samples < base_s + 7 && k < 4000) begin @(negedge clk); k++; end
        chk("cont_progress", 32'(samples >= base_s + 7), 32'd1);
        @(posedge clk); #1;
        scan_en = 1'b0;
        wait_done(base_done + 4, 1000, "cont_done");
        cyc(5);
        chk("cont_exp_left", 32'(exp_q.size()), 32'd0);
        chk("cont_done_exact", 32'(done_cnt - base_done), 32'd4);
        chk("cont_idle", 32'(busy), 32'd0);

        // Reset during a read frame's tx phase.
        chan_mask = 32'h0000_0001; scan_en = 1'b1;
        k = 0;
        while (!(rd_frame && spi_tx_tvalid) && k < 1000) begin @(negedge clk); k++; end
        chk("rst_hit_read_tx", 32'(rd_frame && spi_tx_tvalid), 32'd1);
        @(posedge clk); #1;
        rst = 1'b1; scan_en = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("mrst_mux", 32'({mux_sel, mux_en}), 32'd0);
        chk("mrst_tx", 32'({spi_tx_tvalid, spi_tx_tdata}), 32'd0);
        chk("mrst_rx_tready", 32'(spi_rx_tready), 32'd0);
        chk("mrst_m_axis", m_axis_tdata, 32'd0);
        chk("mrst_m_tvalid", 32'(m_axis_tvalid), 32'd0);
        chk("mrst_busy_done", 32'({busy, scan_done}), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0; exp_q.delete(); m_seq = 8'd0;
        cyc(3);

        // 256 empty scans wrap the sequence number back to 0.
        chan_mask = 32'd0; base_done = done_cnt; base_tx = tx_bytes;
        for (int i = 0; i < 256; i++) begin
            trig();
            cyc(1);
            m_seq++;
        end
        cyc(3);
        chk("wrap_done_count", 32'(done_cnt - base_done), 32'd256);
        chk("wrap_no_spi", 32'(tx_bytes - base_tx), 32'd0);
        chan_mask = 32'h4000_0000; base_done = done_cnt;
        expect_scan(chan_mask);
        trig();
        wait_done(base_done + 1, 600, "wrap_scan_done");
        chk("wrap_tag_seq", 32'(last_word[23:16]), 32'd0);
        chk("wrap_tag_chan", 32'(last_word[28:24]), 32'd30);

`ifdef ADS868X_SCAN_PPS_SYNC_EN
        // scan_en scans wait for each pps rising edge.
        chan_mask = 32'h0000_0001; base_tx = tx_bytes; base_done = done_cnt;
        expect_scan(chan_mask);
        scan_en = 1'b1;
        cyc(100);
        chk("pps_wait_first", 32'(tx_bytes - base_tx), 32'd0);
        pps = 1'b1; cyc(2); pps = 1'b0;
        wait_done(base_done + 1, 600, "pps_first_done");
        base_tx = tx_bytes;
        cyc(100);
        chk("pps_wait_second", 32'(tx_bytes - base_tx), 32'd0);
        expect_scan(chan_mask);
        pps = 1'b1; cyc(2); pps = 1'b0;
        cyc(3);
        scan_en = 1'b0;
        wait_done(base_done + 2, 600, "pps_second_done");
        chk("pps_exp_left", 32'(exp_q.size()), 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/ads868x_scan_sched.md
# ads868x_scan_sched

- Sequences the ADS868x SPI ADC across the 32 external analog-mux channels (3-bit select × 4 bank enables).
- Per enabled channel: drives the mux, waits for settling, issues a conversion frame, then a read frame over the 8-bit AXI4-Stream SPI byte interface.
- Emits each tagged 16-bit result on an output stream.
- Sits between the register block (scan control, channel mask) and `axis_spi_master`; owns both SPI byte streams while busy.

## Interface

Parameters
- `SETTLE_CYCLES`, 200: mux settling wait after a channel switch, clk cycles (≥1).
- `CONV_CYCLES`, 100: wait between end of conversion frame and start of read frame (≥1).

Ports
- `clk` in 1: single clock.
- `rst` in 1: reset, synchronous, active-high.
- `scan_en` in 1: level; scan continuously while high.
- `scan_trig` in 1: pulse; run one scan when idle.
- `chan_mask` in 32: bit n enables channel n; sampled at scan start.
- `pps` in 1: pulse-per-second; used only with the Configuration macro.
- `mux_sel` out 3: analog mux select = channel[2:0].
- `mux_en` out 4: one-hot bank enable = 1 << channel[4:3]; bit0 TCH_A, bit1 PCH_A, bit2 TCH_B, bit3 PCH_B.
- `spi_tx_tdata` out 8, `spi_tx_tvalid` out 1, `spi_tx_tready` in 1: command bytes to the SPI master.
- `spi_rx_tdata` in 8, `spi_rx_tvalid` in 1, `spi_rx_tready` out 1: bytes received from the SPI master.
- `m_axis_tdata` out 32: sample word. [15:0] ADC code, [23:16] scan sequence number, [28:24] channel, [31:29] zero.
- `m_axis_tvalid` out 1, `m_axis_tready` in 1: sample output handshake.
- `busy` out 1: high in any state other than IDLE.
- `scan_done` out 1: one-cycle pulse at end of each scan.

## Operation

States: IDLE, BBM, SETTLE, CONV_TX, CONV_RX, CONV_WAIT, READ_TX, READ_RX, OUTPUT.

- **Scan start (IDLE):** triggered by `scan_trig`, or by `scan_en` high.
  - Latches `chan_mask`.
  - Locates the lowest set bit.
  - Mask zero: `scan_done` pulses, sequence number increments, no SPI traffic, back to IDLE.
- **BBM:** one cycle with `mux_en`=0; loads `mux_sel` with the new channel.
- **SETTLE:** `mux_en` driven to the channel's one-hot value; counts `SETTLE_CYCLES`.
- **CONV_TX:** sends 4 bytes of 0x00 with `spi_tx_tvalid` held high continuously, so the SPI master keeps SS asserted. The frame ends when the tx stream goes idle.
- **CONV_RX:** waits for 4 rx bytes and discards them. `spi_rx_tready` is always 1, outside reset.
- **CONV_WAIT:** counts `CONV_CYCLES`.
- **READ_TX / READ_RX:** same 4-byte exchange. ADC code = {rx byte0, rx byte1}, MSB first; bytes 2–3 discarded.
- **OUTPUT:** `m_axis_tvalid` high with a stable word until `m_axis_tready`; the sequencer stalls (no backpressure loss).
- **Next channel:** after the handshake, advance to the next higher set bit of the latched mask (go to BBM).
  - If none remain, pulse `scan_done` and increment the sequence number (8-bit, 255→0).
  - Then restart from BBM if `scan_en` is still high, else return to IDLE.
- **Mid-scan changes:**
  - `scan_en` falling mid-scan: the current scan completes, then IDLE.
  - `chan_mask` changes mid-scan are ignored until the next scan start.
  - `scan_trig` while busy is ignored.
- **`mux_en` between scans:** keeps the last channel's value in IDLE, and stays one-hot until the next BBM.

## Timing

- Reset values:
  - `mux_sel`=0, `mux_en`=0.
  - `spi_tx_tvalid`=0, `spi_tx_tdata`=0, `spi_rx_tready`=0.
  - `m_axis_tvalid`=0, `m_axis_tdata`=0.
  - `busy`=0, `scan_done`=0, sequence number 0, state IDLE.
- `rst` asserted mid-operation: all of the above take effect the next edge. Any pending sample is dropped; partial SPI frames are abandoned.
- Scan start: trigger sampled at edge N → BBM at N+1, SETTLE from N+2, CONV_TX entered after exactly `SETTLE_CYCLES` SETTLE cycles.
- Tx byte advances only on `spi_tx_tvalid && spi_tx_tready`. The CONV_TX→CONV_RX transition follows the 4th accepted byte; `spi_tx_tvalid` deasserts the cycle after.
- Rx byte counted only on `spi_rx_tvalid` (tready=1).
- `scan_done` is asserted in the cycle after the last OUTPUT handshake (or after the empty-mask start).
- All outputs registered.

## Configuration

- `ADS868X_SCAN_PPS_SYNC_EN` defined:
  - a scan started by `scan_en` (initial or continuous restart) waits in IDLE for a `pps` rising edge (registered edge detect);
  - `scan_trig` still starts immediately.
- Not defined: `pps` is ignored and continuous scans start back-to-back.

## Test plan

- **Single-channel scan:** `chan_mask`=0x0000_0001, pulse `scan_trig`, SPI model returns bytes A5 3C 00 00 on the read frame.
  - Expect `mux_en`=0001, `mux_sel`=0.
  - Exactly 8 tx bytes of 0x00.
  - One sample 0x0000_A53C.
  - `scan_done` once.
- **Multi-bank:** mask 0x8000_0101.
  - Expect channels 0, 8, 31 in order; `mux_en` 0001, 0010, 1000.
  - One BBM cycle with `mux_en`=0 before each.
  - Tags 0x00, 0x08, 0x1F.
- **Backpressure:** hold `m_axis_tready`=0 for 500 cycles.
  - Expect the word stable and no SPI traffic until the handshake.
- **Empty mask and wrap:** mask 0, 256 `scan_trig` pulses.
  - Expect 256 `scan_done` pulses, no SPI bytes, and sequence 0 in the next sample tag.
- **Continuous scan and reset:**
  - `scan_en`=1 with mask 0x3: continuous samples, sequence incrementing.
  - `rst` mid-READ_TX: all outputs return to reset values next cycle.
- **PPS sync (macro defined):** `scan_en`=1.
  - No SPI activity until the `pps` edge.
  - The second scan starts only on the next `pps`.
